// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, sequencer state encoding and op decode helpers.
package alu_pkg;

    localparam int ALU_SIGS = 13;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_NEG  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_SHRA = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        RESP_LO = 2'd2,
        RESP_HI = 2'd3
    } seq_state_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_DIV;
    endfunction

    // Wide ops produce a full 2*BITS result and return two beats.
    function automatic logic is_wide(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [ALU_SIGS-1:0] op_onehot(input logic [3:0] op);
        logic [ALU_SIGS-1:0] v;
        v = '0;
        if (!op_illegal(op))
            v[op] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decoder: binary op code to ALU one-hot control, wide and illegal flags.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0]          i_op,
    output logic [ALU_SIGS-1:0] o_ctrl,
    output logic                o_wide,
    output logic                o_illegal
);

    assign o_ctrl    = op_onehot(i_op);
    assign o_wide    = is_wide(i_op);
    assign o_illegal = op_illegal(i_op);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time through the shared ALU and returns the result in 1 or 2 beats.
// Define ALU_WIDE_WAIT_EN to stretch the MUL/DIV execute window to WIDE_WAIT cycles.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int BITS      = 32,
`ifdef ALU_WIDE_WAIT_EN
    parameter int WIDE_WAIT = 4,
`endif
    parameter int SIG_COUNT = ALU_SIGS
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [BITS-1:0]      req_a,
    input  logic [BITS-1:0]      req_b,
    output logic [SIG_COUNT-1:0] alu_ctrl,
    output logic [BITS-1:0]      alu_x,
    output logic [BITS-1:0]      alu_y,
    input  logic [2*BITS-1:0]    alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BITS-1:0]      rsp_data,
    output logic                 rsp_last,
    output logic                 rsp_err,
    output logic                 busy
);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [3:0]          r_op;
    logic [BITS-1:0]     r_a;
    logic [BITS-1:0]     r_y;
    logic [2*BITS-1:0]   r_z;
    logic [ALU_SIGS-1:0] w_ctrl;
    logic                w_wide;
    logic                w_err;
    logic                w_xfer;
    logic                w_exec_done;

    // Decodes the held op; an illegal op stays in r_op, so its flag doubles as the error bit.
    alu_op_decode u_dec (
        .i_op      (r_op),
        .o_ctrl    (w_ctrl),
        .o_wide    (w_wide),
        .o_illegal (w_err)
    );

    assign req_ready = (r_state == IDLE) && !clr;
    assign w_xfer    = req_valid && req_ready;
    assign busy      = (r_state != IDLE);
    assign alu_x     = r_a;
    assign alu_y     = r_y;

`ifdef ALU_WIDE_WAIT_EN
    localparam int CW = $clog2(WIDE_WAIT + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr)
            r_cnt <= '0;
        else if (w_xfer)
            r_cnt <= is_wide(req_op) ? CW'(WIDE_WAIT - 1) : '0;
        else if (r_state == EXEC && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign w_exec_done = (r_cnt == '0);
`else
    assign w_exec_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_xfer) begin
                    r_op <= req_op;
                    // Illegal requests never reach the ALU, so alu_x/alu_y keep their last values.
                    if (op_illegal(req_op)) begin
                        r_z <= '0;
                    end else begin
                        r_a <= req_a;
                        r_y <= req_b;
                    end
                end
                EXEC: if (w_exec_done) r_z <= alu_result;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        alu_ctrl  = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        case (r_state)
            IDLE: if (w_xfer) w_next = op_illegal(req_op) ? RESP_LO : EXEC;
            EXEC: begin
                alu_ctrl = SIG_COUNT'(w_ctrl);
                if (w_exec_done) w_next = RESP_LO;
            end
            RESP_LO: begin
                rsp_valid = 1'b1;
                rsp_data  = r_z[BITS-1:0];
                rsp_last  = !w_wide || w_err;
                rsp_err   = w_err;
                if (rsp_ready) w_next = (w_wide && !w_err) ? RESP_HI : IDLE;
            end
            RESP_HI: begin
                rsp_valid = 1'b1;
                rsp_data  = r_z[2*BITS-1:BITS];
                rsp_last  = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
